regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator-side controller for the 32x32 register file (RD/WR/EN, rs1/rs2/DR, BusA/BusB port).
//  Accepts operand-fetch requests and writeback requests over valid/ready handshakes.
//  Sequences the register-file strobes, bypasses same-cycle writes, and holds fetched operands
//  for the execute stage. Sits between decode/writeback and the register file.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register index width
//  ZERO_REG  1   1: index 0 reads as 0 and writes to index 0 are suppressed
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  req_valid   in   1       operand-fetch request valid
//  req_ready   out  1       request accepted when req_valid & req_ready
//  req_rs1     in   ADDR_W  source index A
//  req_rs2     in   ADDR_W  source index B
//  op_valid    out  1       op_a/op_b valid
//  op_ready    in   1       downstream takes operands when op_valid & op_ready
//  op_a        out  DATA_W  operand A
//  op_b        out  DATA_W  operand B
//  wb_valid    in   1       writeback valid
//  wb_ready    out  1       constant 1 out of reset, 0 in reset
//  wb_rd       in   ADDR_W  writeback destination index
//  wb_data     in   DATA_W  writeback data
//  rf_en       out  1       register-file enable = rf_rd | rf_wr
//  rf_rd       out  1       register-file read strobe
//  rf_wr       out  1       register-file write strobe
//  rf_rs1      out  ADDR_W  = req_rs1
//  rf_rs2      out  ADDR_W  = req_rs2
//  rf_dr       out  ADDR_W  = wb_rd
//  rf_data_in  out  DATA_W  = wb_data
//  rf_busa     in   DATA_W  register-file BusA, pre-write value, valid the cycle after rf_rd
//  rf_busb     in   DATA_W  register-file BusB, same timing
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, op_valid=0, op_a=op_b=0, byp flags=0.
//   rf_rd=rf_wr=rf_en=0 combinationally; in-flight request is dropped.
//  FSM IDLE/FETCH/VALID. req_ready = (IDLE) | (VALID & op_ready).
//   IDLE  -req accepted->  FETCH
//   FETCH -always->        VALID
//   VALID & op_ready & req_valid -> FETCH (back-to-back)
//   VALID & op_ready & !req_valid -> IDLE
//   VALID & !op_ready -> VALID (hold)
//  Issue cycle (accept): rf_rd=1. Register per-operand bypass flag and data:
//   byp_a = wb_valid & rf_wr_eff & (wb_rd==req_rs1); likewise byp_b; byp_data=wb_data.
//  FETCH cycle: op_a <= ZERO_REG&(rs1==0) ? 0 : byp_a ? byp_data : rf_busa; same rule for op_b.
//  Latency: op_valid asserts 2 cycles after accept; max throughput 1 operand pair per 2 cycles.
//  Read-at-issue semantics: writes in FETCH/VALID cycles never alter latched operands.
//  op_a/op_b stable while op_valid & !op_ready.
//  Writeback: rf_wr_eff = wb_valid & !(ZERO_REG & wb_rd==0); rf_wr=rf_wr_eff. Independent of FSM.
//  Simultaneous read and write to the same index: reader gets new data via bypass.
//  rs1==rs2: both operands get identical values.
// STRUCTURE
//  regfile_pkg: DATA_W/ADDR_W defaults; state enum {IDLE, FETCH, VALID}.
//  One sub-module, regfile_bypass: combinational compare/mux, one instance per operand.
//   Inputs rs, wb_valid, wb_rd, zero flag; outputs byp flag.
// TESTING
//  1 rst_n low mid-FETCH -> op_valid=0, rf_rd=rf_wr=0 same cycle; after release, IDLE with req_ready=1.
//  2 wb x5=0xDEADBEEF; then req rs1=5 rs2=0 -> 2 cycles later op_valid=1, op_a=0xDEADBEEF, op_b=0.
//  3 wb x7=0x00001234 in the same cycle as req rs1=7 rs2=7 -> op_a=op_b=0x00001234 (bypass).
//  4 x9=0x11; req rs1=9; wb x9=0x22 during FETCH -> op_a=0x11; next read of x9 returns 0x22.
//  5 op_ready=0 for 3 cycles -> op_a/op_b stable, req_ready=0.
//    Then op_ready=1 & req_valid=1 -> handoff and rf_rd=1 in the same cycle.
//  6 ZERO_REG=1, wb x0=0xFFFFFFFF -> rf_wr=0; later req rs1=0 -> op_a=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state encoding for the register-file access controller.
// The states are plain localparams so the encoding stays fixed.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_VALID = 2'd2;

endpackage

// File: rtl/regfile_bypass.sv
// Per-operand bypass detect: flags a writeback to the same index in the issue cycle.
// A suppressed write to index 0 never bypasses.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              zero_en,
  output logic              byp
);

  logic wr_eff;

  assign wr_eff = wb_valid & ~(zero_en & (wb_rd == '0));
  assign byp    = wr_eff & (wb_rd == rs);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator-side register-file controller: operand fetch with same-cycle write bypass,
// independent writeback path, and held operands for the execute stage.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_en,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_busa,
  input  logic [DATA_W-1:0] rf_busb
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  state_t            state_q, state_d;
  logic              byp_a_q, byp_a_d;
  logic              byp_b_q, byp_b_d;
  logic              rs1_zero_q, rs1_zero_d;
  logic              rs2_zero_q, rs2_zero_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              byp_a, byp_b;
  logic              wr_eff;
  logic              accept;

  regfile_bypass #(.ADDR_W(ADDR_W)) u_byp_a (
    .rs       (req_rs1),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .zero_en  (ZERO_EN),
    .byp      (byp_a)
  );

  regfile_bypass #(.ADDR_W(ADDR_W)) u_byp_b (
    .rs       (req_rs2),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .zero_en  (ZERO_EN),
    .byp      (byp_b)
  );

  // Strobes are gated by rst_n so nothing reaches the register file while in reset.
  assign wr_eff     = wb_valid & ~(ZERO_EN & (wb_rd == '0));
  assign req_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_VALID) & op_ready));
  assign accept     = req_valid & req_ready;
  assign rf_rd      = accept;
  assign rf_wr      = rst_n & wr_eff;
  assign rf_en      = rf_rd | rf_wr;
  assign wb_ready   = rst_n;
  assign rf_rs1     = req_rs1;
  assign rf_rs2     = req_rs2;
  assign rf_dr      = wb_rd;
  assign rf_data_in = wb_data;
  assign op_valid   = (state_q == ST_VALID);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;

  always_comb begin
    state_d    = state_q;
    byp_a_d    = byp_a_q;
    byp_b_d    = byp_b_q;
    rs1_zero_d = rs1_zero_q;
    rs2_zero_d = rs2_zero_q;
    byp_data_d = byp_data_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Bus carries the pre-write value, so a same-cycle write must come from the bypass.
        state_d = ST_VALID;
        op_a_d  = rs1_zero_q ? '0 : (byp_a_q ? byp_data_q : rf_busa);
        op_b_d  = rs2_zero_q ? '0 : (byp_b_q ? byp_data_q : rf_busb);
      end
      ST_VALID: begin
        if (op_ready) state_d = req_valid ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      byp_a_d    = byp_a;
      byp_b_d    = byp_b;
      rs1_zero_d = ZERO_EN & (req_rs1 == '0);
      rs2_zero_d = ZERO_EN & (req_rs2 == '0);
      byp_data_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byp_a_q    <= 1'b0;
      byp_b_q    <= 1'b0;
      rs1_zero_q <= 1'b0;
      rs2_zero_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      byp_a_q    <= byp_a_d;
      byp_b_q    <= byp_b_d;
      rs1_zero_q <= rs1_zero_d;
      rs2_zero_q <= rs2_zero_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of architectural register contents.
module tb_regfile_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_en, rf_rd, rf_wr;
  logic [4:0]  rf_rs1, rf_rs2, rf_dr;
  logic [31:0] rf_data_in, rf_busa, rf_busb;

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wr(rf_wr),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_dr(rf_dr), .rf_data_in(rf_data_in),
    .rf_busa(rf_busa), .rf_busb(rf_busb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file: synchronous write, registered pre-write read.
  logic [31:0] rf_mem [32];
  logic        env_clr;
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'hBAD0_0000 : 32'h0;
    end else begin
      if (rf_rd) begin
        rf_busa <= rf_mem[rf_rs1];
        rf_busb <= rf_mem[rf_rs2];
      end
      if (rf_wr) rf_mem[rf_dr] <= rf_data_in;
    end
  end

  int          n_cmp;
  int          n_err;
  logic [31:0] ref_regs [32];
  logic        outstanding;
  int          age;
  logic [31:0] exp_a, exp_b;
  logic [31:0] held_a, held_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_valid && wb_rd == rs) return wb_data;
    return ref_regs[rs];
  endfunction

  // One clock cycle: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    logic ev, er, ew;
    #1;
    ev = outstanding && (age >= 2);
    er = rst_n && (!outstanding || (ev && op_ready));
    ew = wb_valid && (wb_rd != 5'd0);
    chk("req_ready", req_ready, er);
    chk("op_valid", op_valid, ev);
    chk("rf_rd", rf_rd, req_valid && er);
    chk("rf_wr", rf_wr, ew);
    chk("rf_en", rf_en, (req_valid && er) || ew);
    chk("wb_ready", wb_ready, 1);
    chk("rf_ports", {rf_rs1, rf_rs2, rf_dr}, {req_rs1, req_rs2, wb_rd});
    chk("rf_data_in", rf_data_in, wb_data);
    if (ev) begin
      chk("op_a", op_a, exp_a);
      chk("op_b", op_b, exp_b);
    end
    if (ev && op_ready) outstanding = 1'b0;
    if (req_valid && er) begin
      exp_a = mread(req_rs1);
      exp_b = mread(req_rs2);
      outstanding = 1'b1;
      age = 0;
    end
    if (ew) ref_regs[wb_rd] = wb_data;
    @(posedge clk);
    if (outstanding) age++;
    @(negedge clk);
  endtask

  task automatic do_req(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic quiet();
    req_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    outstanding = 1'b0; age = 0; exp_a = '0; exp_b = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    env_clr = 1'b1;
    rst_n = 1'b0; op_ready = 1'b0;
    quiet(); req_rs1 = '0; req_rs2 = '0; wb_rd = '0; wb_data = '0;

    // Power-on reset state
    #3;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_rf_en", rf_en, 0);
    @(negedge clk); @(negedge clk);
    env_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Write x5 then read it with x0 as second operand
    do_wb(5'd5, 32'hDEAD_BEEF); tick();
    quiet(); do_req(5'd5, 5'd0); tick();
    quiet(); tick();
    #1;
    chk("t2_op_valid", op_valid, 1);
    chk("t2_op_a", op_a, 32'hDEAD_BEEF);
    chk("t2_op_b", op_b, 32'h0);
    op_ready = 1'b1; tick();
    op_ready = 1'b0;

    // Same-cycle write and read of x7 on both operands
    do_wb(5'd7, 32'h0000_1234); do_req(5'd7, 5'd7); tick();
    quiet(); tick();
    #1;
    chk("t3_op_a", op_a, 32'h0000_1234);
    chk("t3_op_b", op_b, 32'h0000_1234);
    op_ready = 1'b1; tick();
    op_ready = 1'b0;

    // Write during FETCH must not disturb the latched operand
    do_wb(5'd9, 32'h11); tick();
    quiet(); do_req(5'd9, 5'd3); tick();
    quiet(); do_wb(5'd9, 32'h22); tick();
    quiet();
    #1;
    chk("t4_op_a_old", op_a, 32'h11);
    op_ready = 1'b1; tick();
    do_req(5'd9, 5'd9); tick();
    quiet(); tick();
    #1;
    chk("t4_op_a_new", op_a, 32'h22);
    chk("t4_op_b_new", op_b, 32'h22);
    tick();

    // Backpressure hold, then handoff with a new request in the same cycle
    op_ready = 1'b0;
    do_req(5'd5, 5'd7); tick();
    quiet(); tick();
    held_a = op_a; held_b = op_b;
    do_req(5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_a", op_a, held_a);
      chk("t5_hold_b", op_b, held_b);
      chk("t5_req_ready", req_ready, 0);
    end
    op_ready = 1'b1; do_req(5'd3, 5'd4);
    #1;
    chk("t5_handoff_rd", rf_rd, 1);
    chk("t5_handoff_ready", req_ready, 1);
    tick();
    quiet(); tick(); tick();

    // Writes to x0 are dropped; x0 reads as zero
    do_wb(5'd0, 32'hFFFF_FFFF);
    #1;
    chk("t6_rf_wr", rf_wr, 0);
    tick();
    quiet(); do_req(5'd0, 5'd5); tick();
    quiet(); tick();
    #1;
    chk("t6_op_a", op_a, 32'h0);
    chk("t6_op_b", op_b, 32'hDEAD_BEEF);
    tick();

    // Reset asserted mid-FETCH
    op_ready = 1'b0;
    do_req(5'd9, 5'd9); tick();
    rst_n = 1'b0; do_wb(5'd3, 32'h5555_AAAA);
    #1;
    chk("t1_op_valid", op_valid, 0);
    chk("t1_rf_rd", rf_rd, 0);
    chk("t1_rf_wr", rf_wr, 0);
    chk("t1_rf_en", rf_en, 0);
    chk("t1_wb_ready", wb_ready, 0);
    @(negedge clk); @(negedge clk);
    quiet(); rst_n = 1'b1;
    outstanding = 1'b0; age = 0;
    #1;
    chk("t1_req_ready", req_ready, 1);
    chk("t1_op_a", op_a, 0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_rs1   = 5'($urandom_range(0, 7));
      req_rs2   = 5'($urandom_range(0, 7));
      op_ready  = ($urandom_range(0, 99) < 70);
      wb_valid  = ($urandom_range(0, 99) < 50);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      tick();
    end
    quiet(); op_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
